// File: rtl/cla_nibble_arbiter.sv
// Two-requester round-robin arbiter feeding a nibble-serial carry-lookahead adder.
// One 4-bit lookahead slice is evaluated per CALC cycle; the result is held in DONE until taken.
module cla_nibble_arbiter #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [4*NIBBLES-1:0]   res_sum,
    output logic                   res_cout,
    output logic                   res_id,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            cout_q;
    logic            id_q;
    logic            last_id;

    logic            grant_id;
    logic            accept;
    logic [3:0]      slice_a;
    logic [3:0]      slice_b;
    logic [3:0]      slice_sum;
    logic            slice_c4;

    // Returns {c4, sum[3:0]}; every carry is a flat sum of products over g/p and c0.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that was not served last wins.
                if (req0_valid && req1_valid) grant_id = ~last_id;
                else                          grant_id = req1_valid;
                req0_ready = req0_valid && !grant_id;
                req1_ready = req1_valid &&  grant_id;
                accept     = req0_ready || req1_ready;
                if (accept) state_next = CALC;
            end
            CALC: begin
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                slice_a = a_q[4*i +: 4];
                slice_b = b_q[4*i +: 4];
            end
        end
        {slice_c4, slice_sum} = cla4(slice_a, slice_b, carry);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: operand registers carry no reset; they are always reloaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= grant_id ? req1_a : req0_a;
            b_q <= grant_id ? req1_b : req0_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            last_id <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        id_q    <= grant_id;
                        last_id <= grant_id;
                        carry   <= grant_id ? req1_cin : req0_cin;
                        idx     <= '0;
                    end
                end
                CALC: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IW'(i)) sum_q[4*i +: 4] <= slice_sum;
                    end
                    carry <= slice_c4;
                    if (idx == LAST_IDX) begin
                        cout_q <= slice_c4;
                        idx    <= '0;
                    end else begin
                        idx    <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_cla_nibble_arbiter.sv
// Self-checking bench: directed and random operations against an arithmetic reference model
// (a + b + cin at full width, round-robin grant from the last-served requester).
module tb_cla_nibble_arbiter;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_cout, res_id, busy;
    logic [W-1:0] res_sum;

    logic         s_req0_valid, s_req0_ready, s_req0_cin;
    logic         s_req1_valid, s_req1_ready, s_req1_cin;
    logic [3:0]   s_req0_a, s_req0_b, s_req1_a, s_req1_b;
    logic         s_res_valid, s_res_ready, s_res_cout, s_res_id, s_busy;
    logic [3:0]   s_res_sum;

    int checks   = 0;
    int failures = 0;
    int last_served;

    cla_nibble_arbiter #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
        .res_id(res_id), .busy(busy)
    );

    cla_nibble_arbiter #(.NIBBLES(1)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_cin(s_req0_cin),
        .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_cin(s_req1_cin),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_sum(s_res_sum), .res_cout(s_res_cout),
        .res_id(s_res_id), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: grant check, accept, latency count, result check, optional DONE stall, handshake.
    task automatic do_txn(input logic v0, input logic v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                          input int stall, output longint t_acc);
        int           gid;
        int           cnt;
        logic [W:0]   full;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        res_ready  = 1'b0;
        #1;
        if (v0 && v1) gid = (last_served == 1) ? 0 : 1;
        else          gid = v1 ? 1 : 0;
        check("grant_ready0", req0_ready, gid == 0);
        check("grant_ready1", req1_ready, gid == 1);
        if (gid == 0) full = {1'b0, a0} + {1'b0, b0} + {{W{1'b0}}, c0};
        else          full = {1'b0, a1} + {1'b0, b1} + {{W{1'b0}}, c1};
        last_served = gid;
        @(posedge clk);
        t_acc = $time;
        #1;
        if (gid == 0) begin req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom); end
        else          begin req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom); end
        check("calc_busy", busy, 1);
        check("calc_readys", {req0_ready, req1_ready}, 0);
        cnt = 0;
        while (!res_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("latency", cnt, N);
        check("sum", res_sum, full[W-1:0]);
        check("cout", res_cout, full[W]);
        check("id", res_id, gid);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", res_valid, 1);
            check("stall_sum", res_sum, full[W-1:0]);
            check("stall_cout", res_cout, full[W]);
            check("stall_id", res_id, gid);
            check("stall_readys", {req0_ready, req1_ready}, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("release", {res_valid, busy}, 0);
    endtask

    initial begin
        longint t_now;
        longint t_prev;
        logic   v0, v1;
        logic   seen_valid;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
        res_ready  = 0;
        s_req0_valid = 0; s_req0_a = '0; s_req0_b = '0; s_req0_cin = 0;
        s_req1_valid = 0; s_req1_a = '0; s_req1_b = '0; s_req1_cin = 0;
        s_res_ready  = 0;
        last_served  = 1;
        rst_n        = 1'b0;
        repeat (2) tick();

        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", res_sum, 0);
        check("rst_cout", res_cout, 0);
        check("rst_id", res_id, 0);
        check("rst_readys", {req0_ready, req1_ready}, 0);
        check("rst_small_valid", s_res_valid, 0);
        rst_n = 1'b1;
        tick();

        // Carry ripples from nibble 1 into nibble 2.
        do_txn(1, 0, 16'h00FF, 16'h0001, 0, 16'h0, 16'h0, 0, 0, t_now);
        // Carry-in propagates through every slice into carry-out.
        do_txn(0, 1, 16'h0, 16'h0, 0, 16'hFFFF, 16'h0000, 1, 0, t_now);

        // Both requesters held valid with immediate result acceptance: strict alternation, fixed spacing.
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1, W'($urandom), W'($urandom), 1'($urandom),
                   W'($urandom), W'($urandom), 1'($urandom), 0, t_now);
            if (i > 0) check("rr_spacing", t_now - t_prev, 6 * 10);
            t_prev = t_now;
        end

        // Consumer stalls three cycles in DONE.
        do_txn(1, 1, 16'h1234, 16'hABCD, 1, 16'h8000, 16'h8000, 0, 3, t_now);

        // Reset during the third slice aborts the operation.
        req0_valid = 1; req1_valid = 1;
        #1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_served = 1;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        check("abort_ready0", req0_ready, 1);
        check("abort_ready1", req1_ready, 0);
        req0_valid = 0; req1_valid = 0;
        seen_valid = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            tick();
            if (res_valid) seen_valid = 1'b1;
        end
        check("abort_no_result", seen_valid, 0);

        // Randomized operations with random valid patterns and stalls.
        for (int i = 0; i < 24; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            do_txn(v0, v1, W'($urandom), W'($urandom), 1'($urandom),
                   W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), t_now);
        end
        req0_valid = 0; req1_valid = 0;

        // Single-nibble instance: result one edge after accept.
        s_req0_valid = 1; s_req0_a = 4'hF; s_req0_b = 4'h1; s_req0_cin = 0;
        #1;
        check("small_ready0", s_req0_ready, 1);
        tick();
        s_req0_valid = 0;
        check("small_calc_valid", s_res_valid, 0);
        tick();
        check("small_valid", s_res_valid, 1);
        check("small_sum", s_res_sum, 4'h0);
        check("small_cout", s_res_cout, 1);
        check("small_id", s_res_id, 0);
        s_res_ready = 1;
        tick();
        s_res_ready = 0;
        check("small_release", s_res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_nibble_arbiter.md
CLA_NIBBLE_ARBITER -- requirements
Module: cla_nibble_arbiter

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; legal range 1..8; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  block accepts requester 0 this cycle.
REQ-006 req0_a, req0_b  input  W each  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_cin: same widths and meaning as REQ-004..007, for requester 1.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_sum  output  W  a + b + cin, modulo 2^W.
REQ-012 res_cout  output  1  carry out of bit W-1.
REQ-013 res_id  output  1  requester that owns the result (0/1).
REQ-014 busy  output  1  high in CALC and DONE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-016 IDLE: reqN_ready SHALL be high only for the granted requester; at most one ready is high per cycle; both are low outside IDLE.
REQ-017 Grant is round-robin: if only one valid, grant it; if both valid, grant the requester not served last; the last-served pointer updates on each accept.
REQ-018 Accept = reqN_valid && reqN_ready at an edge: capture a, b, cin and the id; move to CALC with slice index 0 and carry register = cin.
REQ-019 CALC: each cycle one 4-bit slice [4i+3:4i] SHALL be added by an internal lookahead slice (g = a&b, p = a^b, c1..c4 from g/p and incoming carry, sum = p ^ {c3,c2,c1,cin}); slice sum is written to res_sum bits, c4 to the carry register, and the index increments.
REQ-020 After slice NIBBLES-1, move to DONE; res_cout = final c4.
REQ-021 Latency: accept at edge T; res_valid SHALL be high starting at edge T+NIBBLES.
REQ-022 DONE: res_valid = 1; res_sum, res_cout, res_id held stable until res_valid && res_ready; then go to IDLE at that edge.
REQ-023 Earliest next accept is in the IDLE cycle after the result handshake (one bubble); throughput one op per NIBBLES+2 cycles.
REQ-024 reqN_valid, operands and res_ready SHALL be ignored in states where they are not sampled; operand changes after accept do not affect the result.
REQ-025 Requesters SHALL hold valid and operands until accepted; the block does not drop a pending valid.
REQ-026 res_sum bits not yet written in CALC are unspecified; they are observable only when res_valid = 1.

Reset
REQ-027 On an edge with rst_n = 0: state = IDLE, res_valid = 0, busy = 0, res_sum = 0, res_cout = 0, res_id = 0, slice index = 0, carry register = 0, last-served = 1 (requester 0 wins the first tie).
REQ-028 Reset in CALC or DONE SHALL abort the operation; no res_valid for it is ever produced.
REQ-029 req0_ready/req1_ready are combinational from state and valids; in the cycle after reset the grant is available immediately.

Verification
REQ-030 req0: a=0x00FF, b=0x0001, cin=0 -> res_sum=0x0100, res_cout=0, res_id=0, res_valid exactly 4 edges after accept.
REQ-031 req1: a=0xFFFF, b=0x0000, cin=1 -> res_sum=0x0000, res_cout=1, res_id=1 (carry crosses all slices).
REQ-032 Both valid continuously, res_ready=1 -> accepts alternate 0,1,0,1; each accept 6 cycles apart.
REQ-033 res_ready low 3 cycles in DONE -> res_sum/res_cout/res_id constant, both readys low, no new accept until the handshake.
REQ-034 rst_n low for one edge during CALC slice 2 -> next cycle busy=0, res_valid=0, req0_ready=1 if both valid; no stale result.
REQ-035 NIBBLES=1: a=0xF, b=0x1, cin=0 -> res_sum=0x0, res_cout=1, res_valid 1 edge after accept.
